// File: rtl/icache_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_responder_if
// Purpose  : Core-side request/response bus plus memory-side fill bus for
//            the instruction-cache responder.
// Revision : 1.0 - initial release
// ============================================================================
interface icache_responder_if #(
    parameter int TAG_W = 13
);
    logic             core_reqcyc;
    logic [63:0]      core_req;
    logic [TAG_W-1:0] core_reqtag;
    logic             core_reqack;
    logic             core_respcyc;
    logic [63:0]      core_resp;
    logic [TAG_W-1:0] core_resptag;
    logic             core_respack;
    logic             mem_reqcyc;
    logic [63:0]      mem_req;
    logic [TAG_W-1:0] mem_reqtag;
    logic             mem_reqack;
    logic             mem_respcyc;
    logic [63:0]      mem_resp;
    logic             mem_respack;

    // Responder side: answers the core, initiates fills on memory.
    modport slave (
        input  core_reqcyc, core_req, core_reqtag, core_respack,
        input  mem_reqack, mem_respcyc, mem_resp,
        output core_reqack, core_respcyc, core_resp, core_resptag,
        output mem_reqcyc, mem_req, mem_reqtag, mem_respack
    );

    modport master (
        output core_reqcyc, core_req, core_reqtag, core_respack,
        output mem_reqack, mem_respcyc, mem_resp,
        input  core_reqack, core_respcyc, core_resp, core_resptag,
        input  mem_reqcyc, mem_req, mem_reqtag, mem_respack
    );
endinterface
`default_nettype wire

// File: rtl/icache_responder.sv
`default_nettype none
// ============================================================================
// Module   : icache_responder
// Purpose  : Direct-mapped read-only instruction line store; streams 8x64-bit
//            line bursts to the core, filling from memory on a miss.
// Revision : 1.0 - initial release
// ============================================================================
module icache_responder #(
    parameter int LINES = 64,
    parameter int TAG_W = 13
) (
    input  logic               clk,
    input  logic               reset,
    icache_responder_if.slave  bus
);
    localparam int c_idx    = $clog2(LINES);
    localparam int c_ltag_w = 58 - c_idx;

    localparam logic [2:0] c_s_idle   = 3'd0;
    localparam logic [2:0] c_s_tagchk = 3'd1;
    localparam logic [2:0] c_s_memreq = 3'd2;
    localparam logic [2:0] c_s_fill   = 3'd3;
    localparam logic [2:0] c_s_stream = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [57:0]         r_line_addr;
    logic [TAG_W-1:0]    r_core_tag;
    logic [2:0]          r_beat;
    logic [LINES-1:0]    r_valid;
    logic [c_ltag_w-1:0] r_tag_mem [LINES];
    logic [63:0]         r_data    [LINES*8];
    logic                r_mem_reqcyc;
    logic [63:0]         r_mem_req;
    logic [TAG_W-1:0]    r_mem_reqtag;

    logic [c_idx-1:0]    w_idx;
    logic [c_ltag_w-1:0] w_ltag;
    logic [c_idx+2:0]    w_word_addr;
    logic                w_hit;
    logic                w_unused_offset;

    assign w_idx           = r_line_addr[c_idx-1:0];
    assign w_ltag          = r_line_addr[57:c_idx];
    assign w_word_addr     = {w_idx, r_beat};
    assign w_hit           = r_valid[w_idx] && (r_tag_mem[w_idx] == w_ltag);
    assign w_unused_offset = ^bus.core_req[5:0];

    assign bus.mem_reqcyc  = r_mem_reqcyc;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_reqtag  = r_mem_reqtag;
    assign bus.mem_respack = bus.mem_respcyc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        bus.core_reqack  = 1'b0;
        bus.core_respcyc = 1'b0;
        bus.core_resp    = '0;
        bus.core_resptag = '0;
        case (r_state)
            c_s_idle: begin
                bus.core_reqack = bus.core_reqcyc;
                if (bus.core_reqcyc) begin
                    w_state_next = c_s_tagchk;
                end
            end
            c_s_tagchk: begin
                w_state_next = w_hit ? c_s_stream : c_s_memreq;
            end
            c_s_memreq: begin
                if (bus.mem_reqack) begin
                    w_state_next = c_s_fill;
                end
            end
            c_s_fill: begin
                if (bus.mem_respcyc && (r_beat == 3'd7)) begin
                    w_state_next = c_s_stream;
                end
            end
            c_s_stream: begin
                bus.core_respcyc = 1'b1;
                bus.core_resp    = r_data[w_word_addr];
                bus.core_resptag = r_core_tag;
                if (bus.core_respack && (r_beat == 3'd7)) begin
                    w_state_next = c_s_idle;
                end
            end
            default: begin
                w_state_next = c_s_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= '0;
            r_beat       <= 3'd0;
            r_line_addr  <= '0;
            r_core_tag   <= '0;
            r_mem_reqcyc <= 1'b0;
            r_mem_req    <= '0;
            r_mem_reqtag <= '0;
        end else begin
            case (r_state)
                c_s_idle: begin
                    if (bus.core_reqcyc) begin
                        r_line_addr <= bus.core_req[63:6];
                        r_core_tag  <= bus.core_reqtag;
                    end
                end
                c_s_tagchk: begin
                    r_beat <= 3'd0;
                    if (!w_hit) begin
                        r_mem_reqcyc <= 1'b1;
                        r_mem_req    <= {r_line_addr, 6'b0};
                        r_mem_reqtag <= r_core_tag;
                    end
                end
                c_s_memreq: begin
                    if (bus.mem_reqack) begin
                        r_mem_reqcyc <= 1'b0;
                        r_beat       <= 3'd0;
                    end
                end
                c_s_fill: begin
                    if (bus.mem_respcyc) begin
                        r_beat <= r_beat + 3'd1;
                        // Line becomes visible only once all eight words are in.
                        if (r_beat == 3'd7) begin
                            r_valid[w_idx] <= 1'b1;
                            r_beat         <= 3'd0;
                        end
                    end
                end
                c_s_stream: begin
                    if (bus.core_respack) begin
                        r_beat <= (r_beat == 3'd7) ? 3'd0 : r_beat + 3'd1;
                    end
                end
                default: begin
                    r_beat <= 3'd0;
                end
            endcase
        end
    end

    // Storage arrays carry no reset; validity alone decides whether a line is usable.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == c_s_fill) && bus.mem_respcyc) begin
            r_data[w_word_addr] <= bus.mem_resp;
            if (r_beat == 3'd7) begin
                r_tag_mem[w_idx] <= w_ltag;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_icache_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_responder
// Purpose  : Directed vector bench for icache_responder with a small memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_responder;
    localparam int c_tag_w = 13;

    typedef struct {
        logic [63:0]        addr;
        logic [c_tag_w-1:0] tag;
        logic [63:0]        fill_base;
        bit                 exp_miss;
        logic [63:0]        exp_base;
        int                 stall_beat;
        int                 stall_n;
        bit                 hold_req;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    vec_t vecs[12];

    icache_responder_if #(.TAG_W(c_tag_w)) bus();

    icache_responder #(.LINES(64), .TAG_W(c_tag_w)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_reqack"},   64'(bus.core_reqack),  64'd0);
        check({pfx, "_respcyc"},  64'(bus.core_respcyc), 64'd0);
        check({pfx, "_resp"},     bus.core_resp,         64'd0);
        check({pfx, "_resptag"},  64'(bus.core_resptag), 64'd0);
        check({pfx, "_mreqcyc"},  64'(bus.mem_reqcyc),   64'd0);
        check({pfx, "_mreq"},     bus.mem_req,           64'd0);
        check({pfx, "_mreqtag"},  64'(bus.mem_reqtag),   64'd0);
    endtask

    // One request from acceptance to the last acknowledged beat; memory acks 2 cycles
    // after seeing mem_reqcyc and then streams 8 back-to-back fill beats.
    task automatic run_vec(input int id, input vec_t v);
        int cyc = 0;
        int first_mreq = -1;
        int ack_cyc = -1;
        int fill_n = 0;
        int last_fill = -1;
        int first_resp = -1;
        int last_resp = -1;
        int resp_cycles = 0;
        int got = 0;
        int stalls_left = v.stall_n;
        int stall_word_cycles = 0;
        int ack_cnt = 0;
        while (got < 8 && cyc < 80) begin
            @(posedge clk); #1;
            if (cyc == 0) begin
                bus.core_req    = v.addr;
                bus.core_reqtag = v.tag;
            end
            bus.core_reqcyc  = (cyc == 0) || v.hold_req;
            bus.mem_reqack   = (first_mreq >= 0) && (cyc == first_mreq + 2);
            bus.mem_respcyc  = (ack_cyc >= 0) && (fill_n < 8) && (cyc > ack_cyc);
            bus.mem_resp     = v.fill_base + 64'(fill_n);
            bus.core_respack = !((got == v.stall_beat) && (stalls_left > 0));
            @(negedge clk);
            if (cyc == 0) begin
                check($sformatf("v%0d_reqack_first", id), 64'(bus.core_reqack), 64'd1);
                check($sformatf("v%0d_idle_respcyc", id), 64'(bus.core_respcyc), 64'd0);
            end
            if (bus.core_reqack) ack_cnt++;
            if (bus.mem_reqcyc && first_mreq < 0) begin
                first_mreq = cyc;
                check($sformatf("v%0d_mem_req", id), bus.mem_req, {v.addr[63:6], 6'b0});
                check($sformatf("v%0d_mem_reqtag", id), 64'(bus.mem_reqtag), 64'(v.tag));
            end
            if (bus.mem_reqack) ack_cyc = cyc;
            if (bus.mem_respcyc) begin
                check($sformatf("v%0d_mem_respack", id), 64'(bus.mem_respack), 64'd1);
                fill_n++;
                if (fill_n == 8) last_fill = cyc;
            end
            if (bus.core_respcyc) begin
                if (first_resp < 0) first_resp = cyc;
                last_resp = cyc;
                resp_cycles++;
                check($sformatf("v%0d_beat%0d_data", id, got), bus.core_resp, v.exp_base + 64'(got));
                check($sformatf("v%0d_beat%0d_tag", id, got), 64'(bus.core_resptag), 64'(v.tag));
                if (got == v.stall_beat) stall_word_cycles++;
                if (bus.core_respack) got++;
                else stalls_left--;
            end
            cyc++;
        end
        bus.mem_respcyc = 1'b0;
        bus.mem_reqack  = 1'b0;
        check($sformatf("v%0d_beats_done", id), 64'(got), 64'd8);
        check($sformatf("v%0d_reqack_count", id), 64'(ack_cnt), 64'd1);
        check($sformatf("v%0d_miss", id), 64'(first_mreq >= 0), 64'(v.exp_miss));
        if (v.exp_miss) begin
            check($sformatf("v%0d_mreq_latency", id), 64'(first_mreq), 64'd2);
            check($sformatf("v%0d_stream_after_fill", id), 64'(first_resp), 64'(last_fill + 1));
        end else begin
            check($sformatf("v%0d_hit_latency", id), 64'(first_resp), 64'd2);
        end
        check($sformatf("v%0d_resp_cycles", id), 64'(resp_cycles), 64'(8 + v.stall_n));
        check($sformatf("v%0d_resp_continuous", id), 64'(last_resp - first_resp + 1), 64'(resp_cycles));
        if (v.stall_n > 0)
            check($sformatf("v%0d_stall_hold", id), 64'(stall_word_cycles), 64'(v.stall_n + 1));
    endtask

    task automatic reset_mid_fill();
        int cyc = 0;
        @(posedge clk); #1;
        bus.core_reqcyc = 1'b1;
        bus.core_req    = 64'h3000_00C0;
        bus.core_reqtag = 13'h0AB;
        @(posedge clk); #1;
        bus.core_reqcyc = 1'b0;
        while (!bus.mem_reqcyc && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_mreq_seen", 64'(bus.mem_reqcyc), 64'd1);
        bus.mem_reqack = 1'b1;
        @(posedge clk); #1;
        bus.mem_reqack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_respcyc = 1'b1;
            bus.mem_resp    = 64'hEE + 64'(i);
            @(posedge clk); #1;
        end
        reset           = 1'b1;
        bus.mem_respcyc = 1'b0;
        @(posedge clk); #1;
        reset           = 1'b0;
        bus.mem_respcyc = 1'b1;
        bus.mem_resp    = 64'hBAD;
        @(negedge clk);
        check_all_zero("rst_mid");
        check("rst_mid_stray_ack", 64'(bus.mem_respack), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.mem_respcyc = 1'b1;
            @(negedge clk);
            check("stray_respcyc", 64'(bus.core_respcyc), 64'd0);
            check("stray_mreqcyc", 64'(bus.mem_reqcyc), 64'd0);
            check("stray_respack", 64'(bus.mem_respack), 64'd1);
        end
        @(posedge clk); #1;
        bus.mem_respcyc = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        //          addr                    tag      fill     miss exp     stall     hold
        vecs[0]  = '{64'h1000_0040,         13'h011, 64'hA0,  1, 64'hA0,  8, 0, 0};
        vecs[1]  = '{64'h1000_0047,         13'h012, 64'h00,  0, 64'hA0,  8, 0, 0};
        vecs[2]  = '{64'h1000_1040,         13'h013, 64'hB0,  1, 64'hB0,  8, 0, 0};
        vecs[3]  = '{64'h1000_0040,         13'h014, 64'hC0,  1, 64'hC0,  8, 0, 0};
        vecs[4]  = '{64'h1000_0040,         13'h015, 64'h00,  0, 64'hC0,  2, 3, 0};
        vecs[5]  = '{64'h2000_0080,         13'h1FFF,64'hD0,  1, 64'hD0,  8, 0, 1};
        vecs[6]  = '{64'h2000_00BF,         13'h016, 64'h00,  0, 64'hD0,  8, 0, 1};
        vecs[7]  = '{64'h1000_1040,         13'h017, 64'hE0,  1, 64'hE0,  8, 0, 0};
        vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFC0, 13'h000, 64'h10, 1, 64'h10, 8, 0, 0};
        vecs[9]  = '{64'h3000_00C0,         13'h0AC, 64'hF0,  1, 64'hF0,  8, 0, 0};
        vecs[10] = '{64'h3000_00C0,         13'h0AD, 64'h00,  0, 64'hF0,  8, 0, 0};
        vecs[11] = '{64'h1000_1040,         13'h018, 64'h20,  1, 64'h20,  8, 0, 0};

        reset            = 1'b1;
        bus.core_reqcyc  = 1'b0;
        bus.core_req     = '0;
        bus.core_reqtag  = '0;
        bus.core_respack = 1'b0;
        bus.mem_reqack   = 1'b0;
        bus.mem_respcyc  = 1'b0;
        bus.mem_resp     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);
        reset_mid_fill();
        for (int i = 9; i < 12; i++) run_vec(i, vecs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Responder end of the core-side instruction-cache bus; it serves 64-byte line read requests issued by the fetch unit.
- Holds a direct-mapped, read-only line store and checks the tag on every request.
- On a hit, streams the 8 x 64-bit words of the line back to the core. On a miss, first fills the line from the memory-side bus, then streams it.
- Sits between the fetch unit and the shared memory/arbiter port.

Parameters:
- LINES, 64, number of direct-mapped lines; power of two; IDX = log2(LINES).
- TAG_W, 13, width of the request/response tag fields.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- core_reqcyc  in  1  core request valid.
- core_req  in  64  request byte address; bits [5:0] ignored.
- core_reqtag  in  TAG_W  request tag.
- core_reqack  out  1  request accepted.
- core_respcyc  out  1  response beat valid.
- core_resp  out  64  response data beat.
- core_resptag  out  TAG_W  tag of the request being answered.
- core_respack  in  1  core accepts the current beat.
- mem_reqcyc  out  1  line fill request valid.
- mem_req  out  64  fill address; line-aligned, low 6 bits zero.
- mem_reqtag  out  TAG_W  equals the captured core tag.
- mem_reqack  in  1  memory accepted the fill request.
- mem_respcyc  in  1  fill beat valid.
- mem_resp  in  64  fill data beat.
- mem_respack  out  1  tied to mem_respcyc; fill beats are always accepted.

Behaviour:
- Address split: offset = req[5:0] (ignored), index = req[6+IDX-1:6], line tag = req[63:6+IDX].
- Storage: valid[LINES], tag[LINES], data[LINES][8] of 64-bit words.
- States: IDLE, TAGCHK, MEMREQ, FILL, STREAM.
- Reset, synchronous:
  - state = IDLE; all valid bits cleared; beat counter = 0.
  - core_reqack = 0, core_respcyc = 0, core_resp = 0, core_resptag = 0.
  - mem_reqcyc = 0, mem_req = 0, mem_reqtag = 0.
  - Applies mid-operation: any in-flight fill or stream is abandoned, and the partially written line stays invalid.
- IDLE:
  - core_reqack = core_reqcyc, combinational and only in IDLE.
  - When core_reqcyc = 1, capture address and tag and go to TAGCHK next cycle.
  - core_reqcyc is ignored in every other state, and core_reqack is 0 there.
- TAGCHK, one cycle:
  - Hit (valid[index] and tag match) -> STREAM, beat = 0.
  - Miss -> MEMREQ.
- MEMREQ:
  - Registered mem_reqcyc = 1 with mem_req = {captured line address, 6'b0}.
  - Hold until mem_reqack = 1; that cycle clear mem_reqcyc and go to FILL, beat = 0.
- FILL:
  - Each mem_respcyc beat writes data[index][beat], beat += 1.
  - On the 8th beat, set tag[index], set valid[index], go to STREAM with beat = 0.
  - mem_respcyc outside FILL is acked and discarded.
- STREAM:
  - core_respcyc = 1, core_resp = data[index][beat], core_resptag = captured tag.
  - Beats go in ascending word order 0..7, always starting at word 0 regardless of offset.
  - The beat advances only in cycles where core_respack = 1; otherwise the output holds stable.
  - After beat 7 is acked, return to IDLE. core_respcyc is then 0 for at least one cycle, which the core uses as the end-of-burst marker.
- Latency:
  - Hit: request seen in cycle N (reqack), first respcyc in cycle N+2, last beat in N+9 with respack held high.
  - Miss: mem_reqcyc first high in cycle N+2; the stream starts the cycle after the 8th fill beat.
- Counters: 3-bit beat counter; reaching beat 7 is the terminal condition, and it must not wrap into a 9th beat.
- Only one outstanding request at a time; no request queueing.

Test Plan:
- Cold miss:
  - Stimulus: after reset, request 0x1000_0040; memory acks 2 cycles later and returns 0xA0..0xA7.
  - Expected: mem_req = 0x1000_0040, then core receives 0xA0..0xA7 in order with respcyc continuous; reqack pulses exactly once.
- Hit:
  - Stimulus: repeat 0x1000_0047.
  - Expected: no mem_reqcyc; first core respcyc 2 cycles after reqack, data 0xA0..0xA7.
- Conflict miss:
  - Stimulus: with LINES=64, request 0x1000_1040 (same index, different tag).
  - Expected: refill via memory, new data returned; a subsequent 0x1000_0040 misses again.
- Backpressure:
  - Stimulus: hit stream with core_respack low for 3 cycles on beat 2.
  - Expected: core_resp holds word 2 for 4 cycles; 8 beats total, none dropped or repeated.
- Reset mid-fill:
  - Stimulus: reset asserted after 4 fill beats.
  - Expected: all outputs 0 next cycle; re-requesting the same line misses; stray mem_respcyc beats are acked and ignored.
- Busy request:
  - Stimulus: core_reqcyc held high during STREAM.
  - Expected: core_reqack stays 0 until the cycle after the last beat (IDLE).
